// File: rtl/fifo_ptr_ctrl_pkg.sv
// Shared definitions for the 10-entry FIFO pointer controller:
// geometry, flag thresholds, state encoding and the wrap-around increment.
package fifo_ptr_ctrl_pkg;

    localparam int DEPTH    = 10;
    localparam int AW       = 4;
    localparam int CW       = 5;
    localparam int AF_LEVEL = 8;
    localparam int AE_LEVEL = 2;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_PARTIAL = 2'b01,
        ST_FULL    = 2'b10
    } state_t;

    // Pointer increment that wraps from DEPTH-1 back to zero.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        logic [AW-1:0] nxt_s;
        if (ptr == AW'(DEPTH - 1)) begin
            nxt_s = {AW{1'b0}};
        end else begin
            nxt_s = ptr + AW'(1'b1);
        end
        return nxt_s;
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl_if.sv
// Request/strobe/status bundle between the FIFO controller and its users.
// The controller takes the slave view; the request side takes the master view.
interface fifo_ptr_ctrl_if;
    import fifo_ptr_ctrl_pkg::*;

    logic          clr;
    logic          wr_en;
    logic          rd_en;
    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          ovf_err;
    logic          udf_err;

    modport master (
        output clr, wr_en, rd_en,
        input  mem_we, mem_re, waddr, raddr, count,
               full, empty, almost_full, almost_empty, ovf_err, udf_err
    );

    modport slave (
        input  clr, wr_en, rd_en,
        output mem_we, mem_re, waddr, raddr, count,
               full, empty, almost_full, almost_empty, ovf_err, udf_err
    );

endinterface

// File: rtl/fifo_ptr_ctrl_mod_cnt.sv
// Modulo-DEPTH address counter with enable and synchronous clear.
// Used for both the write and the read pointer.
module mod_cnt
    import fifo_ptr_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [AW-1:0] q
);

    logic [AW-1:0] q_r;

    // Pointer register: clear wins over advance, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= {AW{1'b0}};
        end else if (clr) begin
            q_r <= {AW{1'b0}};
        end else if (en) begin
            q_r <= ptr_inc(q_r);
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// FIFO control unit: accepts push/pop requests, issues memory strobes and
// addresses, tracks occupancy and keeps registered status and error flags.
// The strobes are combinational so storage sees them in the request cycle.
module fifo_ptr_ctrl
    import fifo_ptr_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    fifo_ptr_ctrl_if.slave fifo
);

    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          full_r;
    logic          empty_r;
    logic          af_r;
    logic          ae_r;
    logic          ovf_r;
    logic          udf_r;
    logic          ovf_nxt_s;
    logic          udf_nxt_s;
    logic          wr_acc_s;
    logic          rd_acc_s;
    logic [AW-1:0] wptr_s;
    logic [AW-1:0] rptr_s;

    // A pop frees a slot in the same cycle, so a full FIFO can still take a push
    // alongside it; the reverse bypass (push feeding a pop when empty) is not allowed.
    assign rd_acc_s = fifo.rd_en & ~empty_r & ~fifo.clr;
    assign wr_acc_s = fifo.wr_en & (~full_r | rd_acc_s) & ~fifo.clr;

    mod_cnt u_wptr (
        .clk (clk),
        .rst (rst),
        .clr (fifo.clr),
        .en  (wr_acc_s),
        .q   (wptr_s)
    );

    mod_cnt u_rptr (
        .clk (clk),
        .rst (rst),
        .clr (fifo.clr),
        .en  (rd_acc_s),
        .q   (rptr_s)
    );

    // Next occupancy from the accepted strobes.
    always_comb begin
        count_nxt_s = count_r;
        if (fifo.clr) begin
            count_nxt_s = {CW{1'b0}};
        end else begin
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_nxt_s = count_r + CW'(1'b1);
                2'b01:   count_nxt_s = count_r - CW'(1'b1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Next state of the EMPTY/PARTIAL/FULL machine.
    always_comb begin
        state_nxt_s = state_r;
        if (fifo.clr) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (wr_acc_s) begin
                        state_nxt_s = ST_PARTIAL;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_PARTIAL: begin
                    if ((count_r == CW'(1'b1)) && rd_acc_s && !wr_acc_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else if ((count_r == CW'(DEPTH - 1)) && wr_acc_s && !rd_acc_s) begin
                        state_nxt_s = ST_FULL;
                    end else begin
                        state_nxt_s = ST_PARTIAL;
                    end
                end
                ST_FULL: begin
                    if (rd_acc_s && !wr_acc_s) begin
                        state_nxt_s = ST_PARTIAL;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: state_nxt_s = ST_EMPTY;
            endcase
        end
    end

    // Sticky error flags: set on a refused push / a pop into empty, cleared only by clr.
    always_comb begin
        ovf_nxt_s = ovf_r;
        udf_nxt_s = udf_r;
        if (fifo.clr) begin
            ovf_nxt_s = 1'b0;
            udf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r | (fifo.wr_en & full_r & ~rd_acc_s);
            udf_nxt_s = udf_r | (fifo.rd_en & empty_r);
        end
    end

    // State, occupancy and flag registers; flags derive from next values so they track count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_EMPTY;
            count_r <= {CW{1'b0}};
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            af_r    <= 1'b0;
            ae_r    <= 1'b1;
            ovf_r   <= 1'b0;
            udf_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            full_r  <= (state_nxt_s == ST_FULL);
            empty_r <= (state_nxt_s == ST_EMPTY);
            af_r    <= (count_nxt_s >= CW'(AF_LEVEL));
            ae_r    <= (count_nxt_s <= CW'(AE_LEVEL));
            ovf_r   <= ovf_nxt_s;
            udf_r   <= udf_nxt_s;
        end
    end

    assign fifo.mem_we       = wr_acc_s;
    assign fifo.mem_re       = rd_acc_s;
    assign fifo.waddr        = wptr_s;
    assign fifo.raddr        = rptr_s;
    assign fifo.count        = count_r;
    assign fifo.full         = full_r;
    assign fifo.empty        = empty_r;
    assign fifo.almost_full  = af_r;
    assign fifo.almost_empty = ae_r;
    assign fifo.ovf_err      = ovf_r;
    assign fifo.udf_err      = udf_r;

endmodule
